// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared frame-level state encoding and default bit counts for the CAN controller
package can_pkg;

    typedef enum logic [2:0] {
        INTEGRATE    = 3'd0,
        IDLE         = 3'd1,
        FRAME        = 3'd2,
        INTERMISSION = 3'd3,
        OVERLOAD     = 3'd4,
        ERROR        = 3'd5
    } frame_state_t;

    localparam int IDLE_BITS_DEF         = 11;
    localparam int INTERMISSION_BITS_DEF = 3;
    localparam int MAX_REQ_OVERLOAD_DEF  = 2;
    localparam int WATCHDOG_BITS_DEF     = 64;

    function automatic int cntWidth(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - saturating up-counter with synchronous clear (priority) and count enable
module bit_counter #(
    parameter int LIMIT = 11,
    parameter int WIDTH = $clog2(LIMIT) + 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT_V)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - CAN bit-level frame sequencer; optional watchdog under FRAME_SCHEDULER_WATCHDOG_EN
module frame_scheduler
    import can_pkg::*;
#(
    parameter int IDLE_BITS         = IDLE_BITS_DEF,
    parameter int INTERMISSION_BITS = INTERMISSION_BITS_DEF,
    parameter int MAX_REQ_OVERLOAD  = MAX_REQ_OVERLOAD_DEF,
    parameter int WATCHDOG_BITS     = WATCHDOG_BITS_DEF
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       samplePoint,
    input  logic       canRX,
    input  logic       frameErr,
    input  logic       endFrame,
    input  logic       endError,
    input  logic       endOverload,
    input  logic       overloadReq,
    output logic       isFrame,
    output logic       isError,
    output logic       isOverload,
    output logic       busIdle,
    output logic       sofPulse,
    output logic [2:0] state,
    output logic       timeoutErr
);

    // One counter serves both integration and intermission, so it is sized for the larger limit.
    localparam int CNT_LIMIT = (IDLE_BITS > INTERMISSION_BITS) ? IDLE_BITS : INTERMISSION_BITS;
    localparam int CW        = cntWidth(CNT_LIMIT);
    localparam int RW        = cntWidth(MAX_REQ_OVERLOAD);

    localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLE_BITS - 1);
    localparam logic [CW-1:0] INTER_LAST = CW'(INTERMISSION_BITS - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [RW-1:0] REQ_MAX    = RW'(MAX_REQ_OVERLOAD);

    frame_state_t  stateReg;
    frame_state_t  nextState;
    logic [CW-1:0] bitCnt;
    logic          cntClear;
    logic          cntCount;
    logic [RW-1:0] reqCnt;
    logic          reqInc;
    logic          reqClear;
    logic          sofNext;
    logic          wdFire;

    bit_counter #(
        .LIMIT (CNT_LIMIT),
        .WIDTH (CW)
    ) uBitCnt (
        .clk    (clk),
        .resetN (resetN),
        .clear  (cntClear),
        .enable (cntCount),
        .count  (bitCnt)
    );

`ifdef FRAME_SCHEDULER_WATCHDOG_EN
    localparam int            WW      = cntWidth(WATCHDOG_BITS);
    localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG_BITS - 1);

    logic [WW-1:0] wdCnt;
    logic          wdClear;
    logic          timeoutNext;

    assign wdClear = (nextState != stateReg) || !((stateReg == OVERLOAD) || (stateReg == ERROR));
    assign wdFire  = (wdCnt == WD_LAST);

    bit_counter #(
        .LIMIT (WATCHDOG_BITS),
        .WIDTH (WW)
    ) uWatchdog (
        .clk    (clk),
        .resetN (resetN),
        .clear  (wdClear),
        .enable (samplePoint),
        .count  (wdCnt)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            timeoutErr <= 1'b0;
        end else begin
            timeoutErr <= timeoutNext;
        end
    end
`else
    // Keeps the watchdog parameter referenced when the watchdog is compiled out.
    logic unusedWatchdog;
    assign unusedWatchdog = ^WATCHDOG_BITS;
    assign wdFire         = 1'b0;
    assign timeoutErr     = 1'b0;
`endif

    always_comb begin
        nextState = stateReg;
        cntClear  = 1'b0;
        cntCount  = 1'b0;
        sofNext   = 1'b0;
        reqInc    = 1'b0;
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
        timeoutNext = 1'b0;
`endif
        if (samplePoint) begin
            case (stateReg)
                INTEGRATE: begin
                    if (!canRX) begin
                        cntClear = 1'b1;
                    end else if (bitCnt == IDLE_LAST) begin
                        nextState = IDLE;
                    end else begin
                        cntCount = 1'b1;
                    end
                end
                IDLE: begin
                    if (!canRX) begin
                        nextState = FRAME;
                        sofNext   = 1'b1;
                    end
                end
                FRAME: begin
                    if (frameErr) begin
                        nextState = ERROR;
                    end else if (endFrame) begin
                        nextState = INTERMISSION;
                    end
                end
                INTERMISSION: begin
                    if (frameErr) begin
                        nextState = ERROR;
                    end else if ((bitCnt == '0) && overloadReq && (reqCnt < REQ_MAX)) begin
                        nextState = OVERLOAD;
                        reqInc    = 1'b1;
                    end else if (!canRX && (bitCnt <= CNT_ONE)) begin
                        nextState = OVERLOAD;
                    end else if (bitCnt == INTER_LAST) begin
                        // Dominant on the last intermission bit is a start of frame.
                        if (!canRX) begin
                            nextState = FRAME;
                            sofNext   = 1'b1;
                        end else begin
                            nextState = IDLE;
                        end
                    end else begin
                        cntCount = 1'b1;
                    end
                end
                OVERLOAD: begin
                    if (frameErr) begin
                        nextState = ERROR;
                    end else if (endOverload) begin
                        nextState = INTERMISSION;
                    end else if (wdFire) begin
                        nextState = INTEGRATE;
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
                        timeoutNext = 1'b1;
`endif
                    end
                end
                ERROR: begin
                    if (endError) begin
                        nextState = INTERMISSION;
                    end else if (wdFire) begin
                        nextState = INTEGRATE;
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
                        timeoutNext = 1'b1;
`endif
                    end
                end
                default: nextState = INTEGRATE;
            endcase
        end
        // Every state entry starts the shared bit counter from zero.
        if (nextState != stateReg) begin
            cntClear = 1'b1;
        end
    end

    assign reqClear = (nextState != stateReg) && ((nextState == FRAME) || (nextState == IDLE));
    assign state    = stateReg;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateReg   <= INTEGRATE;
            isFrame    <= 1'b0;
            isError    <= 1'b0;
            isOverload <= 1'b0;
            busIdle    <= 1'b0;
            sofPulse   <= 1'b0;
            reqCnt     <= '0;
        end else begin
            stateReg   <= nextState;
            isFrame    <= (nextState == FRAME);
            isError    <= (nextState == ERROR);
            isOverload <= (nextState == OVERLOAD);
            busIdle    <= (nextState == IDLE);
            sofPulse   <= sofNext;
            if (reqClear) begin
                reqCnt <= '0;
            end else if (reqInc && (reqCnt != REQ_MAX)) begin
                reqCnt <= reqCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - scoreboard bench for frame_scheduler, one task per scenario
module tb_frame_scheduler;
    import can_pkg::*;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       samplePoint = 1'b0;
    logic       canRX = 1'b1;
    logic       frameErr = 1'b0;
    logic       endFrame = 1'b0;
    logic       endError = 1'b0;
    logic       endOverload = 1'b0;
    logic       overloadReq = 1'b0;
    logic       isFrame, isError, isOverload, busIdle, sofPulse, timeoutErr;
    logic [2:0] state;
    logic [8:0] obsV;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [8:0] v;
    } expT;

    typedef struct {
        string      name;
        logic       rx, fe, ef, ee, eo, oq;
        logic [8:0] exp;
    } stepT;

    expT expQ[$];

    // Expected {state, isFrame, isError, isOverload, busIdle, sofPulse, timeoutErr}
    localparam logic [8:0] EINT = {INTEGRATE,    6'b000000};
    localparam logic [8:0] EIDL = {IDLE,         6'b000100};
    localparam logic [8:0] EFRM = {FRAME,        6'b100000};
    localparam logic [8:0] ESOF = {FRAME,        6'b100010};
    localparam logic [8:0] EIMS = {INTERMISSION, 6'b000000};
    localparam logic [8:0] EOVL = {OVERLOAD,     6'b001000};
    localparam logic [8:0] EERR = {ERROR,        6'b010000};
    localparam logic [8:0] ETMO = {INTEGRATE,    6'b000001};

    frame_scheduler dut (
        .clk         (clk),
        .resetN      (resetN),
        .samplePoint (samplePoint),
        .canRX       (canRX),
        .frameErr    (frameErr),
        .endFrame    (endFrame),
        .endError    (endError),
        .endOverload (endOverload),
        .overloadReq (overloadReq),
        .isFrame     (isFrame),
        .isError     (isError),
        .isOverload  (isOverload),
        .busIdle     (busIdle),
        .sofPulse    (sofPulse),
        .state       (state),
        .timeoutErr  (timeoutErr)
    );

    always #5 clk = ~clk;

    assign obsV = {state, isFrame, isError, isOverload, busIdle, sofPulse, timeoutErr};

    function automatic stepT st(input string n, input logic rx, input logic fe, input logic ef,
                                input logic ee, input logic eo, input logic oq, input logic [8:0] exp);
        stepT s;
        s.name = n; s.rx = rx; s.fe = fe; s.ef = ef; s.ee = ee; s.eo = eo; s.oq = oq; s.exp = exp;
        return s;
    endfunction

    // One sample-point strobe; returns on the following falling edge, after the registered update.
    task automatic driveBit(input logic rx, input logic fe, input logic ef, input logic ee,
                            input logic eo, input logic oq);
        @(negedge clk);
        canRX = rx; frameErr = fe; endFrame = ef; endError = ee; endOverload = eo; overloadReq = oq;
        samplePoint = 1'b1;
        @(negedge clk);
        samplePoint = 1'b0;
        canRX = 1'b1; frameErr = 1'b0; endFrame = 1'b0; endError = 1'b0; endOverload = 1'b0;
        overloadReq = 1'b0;
    endtask

    task automatic goIdle();
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 11; i++) driveBit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        expT e;
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        expQ.push_back('{"reset", EINT});
        #1;
        e = expQ.pop_front();
        checks++;
        if (obsV !== e.v) begin
            errors++;
            $display("FAIL %s: got %b, want %b", e.name, obsV, e.v);
        end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_integrate();
        stepT s[$];
        expT  e;
        for (int i = 0; i < 10; i++) s.push_back(st("integ_rec", 1, 0, 0, 0, 0, 0, EINT));
        s.push_back(st("integ_11th", 1, 0, 0, 0, 0, 0, EIDL));
        foreach (s[i]) begin
            expQ.push_back('{s[i].name, s[i].exp});
            driveBit(s[i].rx, s[i].fe, s[i].ef, s[i].ee, s[i].eo, s[i].oq);
            e = expQ.pop_front();
            checks++;
            if (obsV !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %b, want %b", e.name, i, obsV, e.v);
            end
        end
        s.delete();
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 5; i++) s.push_back(st("reint_rec", 1, 0, 0, 0, 0, 0, EINT));
        s.push_back(st("reint_dom6", 0, 0, 0, 0, 0, 0, EINT));
        for (int i = 0; i < 10; i++) s.push_back(st("reint_after", 1, 0, 0, 0, 0, 0, EINT));
        s.push_back(st("reint_11more", 1, 0, 0, 0, 0, 0, EIDL));
        foreach (s[i]) begin
            expQ.push_back('{s[i].name, s[i].exp});
            driveBit(s[i].rx, s[i].fe, s[i].ef, s[i].ee, s[i].eo, s[i].oq);
            e = expQ.pop_front();
            checks++;
            if (obsV !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %b, want %b", e.name, i, obsV, e.v);
            end
        end
    endtask

    task automatic test_frame();
        stepT s[$];
        expT  e;
        goIdle();
        s.push_back(st("idle_ferr_ignored", 1, 1, 0, 0, 0, 0, EIDL));
        s.push_back(st("sof",               0, 0, 0, 0, 0, 0, ESOF));
        s.push_back(st("frame_bit",         1, 0, 0, 0, 0, 0, EFRM));
        s.push_back(st("stray_endError",    1, 0, 0, 1, 0, 0, EFRM));
        s.push_back(st("stray_endOverload", 0, 0, 0, 0, 1, 0, EFRM));
        s.push_back(st("endFrame",          1, 0, 1, 0, 0, 0, EIMS));
        s.push_back(st("inter0",            1, 0, 0, 0, 0, 0, EIMS));
        s.push_back(st("inter1",            1, 0, 0, 0, 0, 0, EIMS));
        s.push_back(st("inter2_idle",       1, 0, 0, 0, 0, 0, EIDL));
        foreach (s[i]) begin
            expQ.push_back('{s[i].name, s[i].exp});
            driveBit(s[i].rx, s[i].fe, s[i].ef, s[i].ee, s[i].eo, s[i].oq);
            e = expQ.pop_front();
            checks++;
            if (obsV !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %b, want %b", e.name, i, obsV, e.v);
            end
        end
    endtask

    task automatic test_reactive_overload();
        stepT s[$];
        expT  e;
        goIdle();
        s.push_back(st("sof",          0, 0, 0, 0, 0, 0, ESOF));
        s.push_back(st("endFrame",     1, 0, 1, 0, 0, 0, EIMS));
        s.push_back(st("inter0",       1, 0, 0, 0, 0, 0, EIMS));
        s.push_back(st("inter1_dom",   0, 0, 0, 0, 0, 0, EOVL));
        s.push_back(st("ovl_bit",      1, 0, 0, 0, 0, 0, EOVL));
        s.push_back(st("endOverload",  1, 0, 0, 0, 1, 0, EIMS));
        s.push_back(st("restart0",     1, 0, 0, 0, 0, 0, EIMS));
        s.push_back(st("restart1",     1, 0, 0, 0, 0, 0, EIMS));
        s.push_back(st("inter2_sof",   0, 0, 0, 0, 0, 0, ESOF));
        s.push_back(st("endFrame2",    1, 0, 1, 0, 0, 0, EIMS));
        s.push_back(st("inter0_dom",   0, 0, 0, 0, 0, 0, EOVL));
        s.push_back(st("endOverload2", 1, 0, 0, 0, 1, 0, EIMS));
        s.push_back(st("tail0",        1, 0, 0, 0, 0, 0, EIMS));
        s.push_back(st("tail1",        1, 0, 0, 0, 0, 0, EIMS));
        s.push_back(st("tail2_idle",   1, 0, 0, 0, 0, 0, EIDL));
        foreach (s[i]) begin
            expQ.push_back('{s[i].name, s[i].exp});
            driveBit(s[i].rx, s[i].fe, s[i].ef, s[i].ee, s[i].eo, s[i].oq);
            e = expQ.pop_front();
            checks++;
            if (obsV !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %b, want %b", e.name, i, obsV, e.v);
            end
        end
    endtask

    task automatic test_requested_overload();
        stepT s[$];
        expT  e;
        goIdle();
        s.push_back(st("sof",           0, 0, 0, 0, 0, 0, ESOF));
        s.push_back(st("endFrame",      1, 0, 1, 0, 0, 0, EIMS));
        s.push_back(st("req1",          1, 0, 0, 0, 0, 1, EOVL));
        s.push_back(st("req1_end",      1, 0, 0, 0, 1, 1, EIMS));
        s.push_back(st("req2",          1, 0, 0, 0, 0, 1, EOVL));
        s.push_back(st("req2_end",      1, 0, 0, 0, 1, 1, EIMS));
        s.push_back(st("req3_refused",  1, 0, 0, 0, 0, 1, EIMS));
        s.push_back(st("req3_bit1",     1, 0, 0, 0, 0, 1, EIMS));
        s.push_back(st("req3_idle",     1, 0, 0, 0, 0, 1, EIDL));
        s.push_back(st("sof_again",     0, 0, 0, 0, 0, 1, ESOF));
        s.push_back(st("endFrame2",     1, 0, 1, 0, 0, 0, EIMS));
        s.push_back(st("req_after_clr", 1, 0, 0, 0, 0, 1, EOVL));
        s.push_back(st("end_after_clr", 1, 0, 0, 0, 1, 0, EIMS));
        s.push_back(st("tail0",         1, 0, 0, 0, 0, 0, EIMS));
        s.push_back(st("tail1",         1, 0, 0, 0, 0, 0, EIMS));
        s.push_back(st("tail2_idle",    1, 0, 0, 0, 0, 0, EIDL));
        foreach (s[i]) begin
            expQ.push_back('{s[i].name, s[i].exp});
            driveBit(s[i].rx, s[i].fe, s[i].ef, s[i].ee, s[i].eo, s[i].oq);
            e = expQ.pop_front();
            checks++;
            if (obsV !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %b, want %b", e.name, i, obsV, e.v);
            end
        end
    endtask

    task automatic test_error_priority();
        stepT s[$];
        expT  e;
        goIdle();
        s.push_back(st("sof",            0, 0, 0, 0, 0, 0, ESOF));
        s.push_back(st("endFrame",       1, 0, 1, 0, 0, 0, EIMS));
        s.push_back(st("inter0_dom",     0, 0, 0, 0, 0, 0, EOVL));
        s.push_back(st("ferr_over_end",  1, 1, 0, 0, 1, 0, EERR));
        s.push_back(st("err_ferr_ign",   0, 1, 0, 0, 0, 0, EERR));
        s.push_back(st("err_stray_eo",   1, 0, 0, 0, 1, 0, EERR));
        s.push_back(st("endError",       1, 0, 0, 1, 0, 0, EIMS));
        s.push_back(st("inter_ferr",     1, 1, 0, 0, 0, 1, EERR));
        s.push_back(st("endError2",      1, 0, 0, 1, 0, 0, EIMS));
        s.push_back(st("inter0",         1, 0, 0, 0, 0, 0, EIMS));
        s.push_back(st("inter1",         1, 0, 0, 0, 0, 0, EIMS));
        s.push_back(st("inter2_sof",     0, 0, 0, 0, 0, 0, ESOF));
        s.push_back(st("frame_ferr_end", 1, 1, 1, 0, 0, 0, EERR));
        s.push_back(st("endError3",      1, 0, 0, 1, 0, 0, EIMS));
        s.push_back(st("tail0",          1, 0, 0, 0, 0, 0, EIMS));
        s.push_back(st("tail1",          1, 0, 0, 0, 0, 0, EIMS));
        s.push_back(st("tail2_idle",     1, 0, 0, 0, 0, 0, EIDL));
        foreach (s[i]) begin
            expQ.push_back('{s[i].name, s[i].exp});
            driveBit(s[i].rx, s[i].fe, s[i].ef, s[i].ee, s[i].eo, s[i].oq);
            e = expQ.pop_front();
            checks++;
            if (obsV !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %b, want %b", e.name, i, obsV, e.v);
            end
        end
    endtask

    task automatic test_reset_midframe();
        stepT s[$];
        expT  e;
        goIdle();
        driveBit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        resetN = 1'b0;
        expQ.push_back('{"async_reset", EINT});
        #1;
        e = expQ.pop_front();
        checks++;
        if (obsV !== e.v) begin
            errors++;
            $display("FAIL %s: got %b, want %b", e.name, obsV, e.v);
        end
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 10; i++) s.push_back(st("post_reset_rec", 1, 0, 0, 0, 0, 0, EINT));
        s.push_back(st("post_reset_idle", 1, 0, 0, 0, 0, 0, EIDL));
        foreach (s[i]) begin
            expQ.push_back('{s[i].name, s[i].exp});
            driveBit(s[i].rx, s[i].fe, s[i].ef, s[i].ee, s[i].eo, s[i].oq);
            e = expQ.pop_front();
            checks++;
            if (obsV !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %b, want %b", e.name, i, obsV, e.v);
            end
        end
    endtask

    task automatic test_watchdog();
        stepT s[$];
        expT  e;
        goIdle();
        s.push_back(st("sof",        0, 0, 0, 0, 0, 0, ESOF));
        s.push_back(st("endFrame",   1, 0, 1, 0, 0, 0, EIMS));
        s.push_back(st("inter0_dom", 0, 0, 0, 0, 0, 0, EOVL));
        for (int i = 0; i < 63; i++) s.push_back(st("ovl_hold", 1, 0, 0, 0, 0, 0, EOVL));
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
        s.push_back(st("wd_fire",    1, 0, 0, 0, 0, 0, ETMO));
        s.push_back(st("wd_after",   1, 0, 0, 0, 0, 0, EINT));
`else
        s.push_back(st("no_wd_64",   1, 0, 0, 0, 0, 0, EOVL));
        s.push_back(st("no_wd_end",  1, 0, 0, 0, 1, 0, EIMS));
`endif
        foreach (s[i]) begin
            expQ.push_back('{s[i].name, s[i].exp});
            driveBit(s[i].rx, s[i].fe, s[i].ef, s[i].ee, s[i].eo, s[i].oq);
            e = expQ.pop_front();
            checks++;
            if (obsV !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %b, want %b", e.name, i, obsV, e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_integrate();
        test_frame();
        test_reactive_overload();
        test_requested_overload();
        test_error_priority();
        test_reset_midframe();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
